alu_complete_buffer: RTL

Completion buffer between one ALU and the common data bus (CDB) arbiter. Captures each single-cycle ALU result with its destination physical register and ROB index, and holds it in an in-order FIFO until the arbiter grants a CDB slot. Decouples ALU issue from CDB contention in the 3-way back end, with one instance per ALU. Provides early back-pressure to the issue stage and flushes on branch-mispredict squash.

---
 rtl/alu_complete_buffer_pkg.sv | 19 +
 rtl/alu_complete_buffer_if.sv | 37 +++
 rtl/alu_complete_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/alu_complete_buffer_pkg.sv
// Shared CDB definitions: result width, register/ROB index widths and the
// packet that travels from an ALU completion buffer onto the common data bus.
`ifndef XLEN
`define XLEN 32
`endif

package alu_complete_buffer_pkg;

    localparam int XLEN  = `XLEN;
    localparam int PRF_W = 6;
    localparam int ROB_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [PRF_W-1:0] dest_preg;
        logic [ROB_W-1:0] rob_idx;
    } CDB_PACKET;

endpackage

// File: rtl/alu_complete_buffer_if.sv
// ALU-side and CDB-side signals of one completion buffer. The master is the
// surrounding pipeline (ALU, issue stage, CDB arbiter, squash source); the
// slave is the buffer itself.
interface alu_complete_buffer_if #(
    parameter int PRF_W = alu_complete_buffer_pkg::PRF_W,
    parameter int ROB_W = alu_complete_buffer_pkg::ROB_W,
    parameter int CNT_W = 3
);

    logic                                     squash;
    logic                                     in_valid;
    logic [alu_complete_buffer_pkg::XLEN-1:0] in_result;
    logic [PRF_W-1:0]                         in_dest_preg;
    logic [ROB_W-1:0]                         in_rob_idx;
    logic                                     in_ready;
    logic                                     almost_full;
    logic                                     cdb_grant;
    logic                                     out_valid;
    logic [alu_complete_buffer_pkg::XLEN-1:0] out_result;
    logic [PRF_W-1:0]                         out_dest_preg;
    logic [ROB_W-1:0]                         out_rob_idx;
    logic [CNT_W-1:0]                         count;
    logic                                     overflow;

    modport master (
        output squash, in_valid, in_result, in_dest_preg, in_rob_idx, cdb_grant,
        input  in_ready, almost_full, out_valid, out_result, out_dest_preg,
               out_rob_idx, count, overflow
    );

    modport slave (
        input  squash, in_valid, in_result, in_dest_preg, in_rob_idx, cdb_grant,
        output in_ready, almost_full, out_valid, out_result, out_dest_preg,
               out_rob_idx, count, overflow
    );

endinterface

// File: rtl/alu_complete_buffer.sv
// In-order completion FIFO between one single-cycle ALU and the CDB arbiter.
// Holds results until granted, raises almost_full one entry early so the
// issue stage can stop a cycle ahead of the ALU, and flushes on squash.
module alu_complete_buffer
    import alu_complete_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PRF_W = alu_complete_buffer_pkg::PRF_W,
    parameter int ROB_W = alu_complete_buffer_pkg::ROB_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    alu_complete_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    CDB_PACKET        mem_q [DEPTH];
    CDB_PACKET        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    CDB_PACKET        head_pkt;

    // Status flags derived only from registered occupancy (no path from cdb_grant).
    always_comb begin
        in_ready  = (count_q < CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        head_pkt  = mem_q[head_q];
    end

    assign bus.in_ready      = in_ready;
    assign bus.almost_full   = (count_q >= CNT_W'(DEPTH - 1));
    assign bus.out_valid     = out_valid;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.out_result    = head_pkt.result;
    assign bus.out_dest_preg = PRF_W'(head_pkt.dest_preg);
    assign bus.out_rob_idx   = ROB_W'(head_pkt.rob_idx);

    // Next-state: squash flushes the pointers, otherwise push/pop update the queue.
    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = bus.in_valid && in_ready;
        pop        = bus.cdb_grant && out_valid;
        // A result arriving while full is lost; remember it until reset.
        overflow_d = overflow_q || (bus.in_valid && !in_ready);

        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = '{result:    bus.in_result,
                                  dest_preg: PRF_W'(bus.in_dest_preg),
                                  rob_idx:   ROB_W'(bus.in_rob_idx)};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset; storage is cleared so head fields are never X.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments; the array is reset too because out_* are read from it while empty.
        if (reset) begin
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
